upload_arbiter: RTL and testbench



---
 rtl/upload_arbiter_if.sv | 44 ++++
 rtl/upload_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_upload_arbiter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/upload_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : upload_arbiter_if
//  Description : Bundles the per-source upload inputs and the merged upload
//                output channel of upload_arbiter.
//                  in_req    [N_SRC]    per-source packet-in-progress
//                  in_data   [8*N_SRC]  per-source data byte
//                  in_source [8*N_SRC]  per-source ID byte
//                  in_valid  [N_SRC]    per-source byte strobe
//                  out_req              high for one whole forwarded packet
//                  out_data  [8]        forwarded byte
//                  out_source[8]        ID byte stored with out_data
//                  out_valid            out_data/out_source valid
//                  out_ready            downstream accepts on valid & ready
//                  drop_flag [N_SRC]    sticky per-source loss flag
//                slave  : seen by the arbiter
//                master : seen by the handlers / command processor side
//  Revision    : 1.0 - initial release
// ============================================================================
interface upload_arbiter_if #(
    parameter int N_SRC = 2
);
    logic [N_SRC-1:0]   in_req;
    logic [8*N_SRC-1:0] in_data;
    logic [8*N_SRC-1:0] in_source;
    logic [N_SRC-1:0]   in_valid;
    logic               out_req;
    logic [7:0]         out_data;
    logic [7:0]         out_source;
    logic               out_valid;
    logic               out_ready;
    logic [N_SRC-1:0]   drop_flag;

    modport slave (
        input  in_req, in_data, in_source, in_valid, out_ready,
        output out_req, out_data, out_source, out_valid, drop_flag
    );

    modport master (
        output in_req, in_data, in_source, in_valid, out_ready,
        input  out_req, out_data, out_source, out_valid, drop_flag
    );
endinterface
`default_nettype wire

// File: rtl/upload_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : upload_arbiter
//  Description : Merges byte-streamed upload packets from N_SRC handlers into
//                one upload channel. Each source has a one-entry staging
//                register feeding its own FIFO; complete packets are
//                forwarded whole, one at a time, in round-robin order.
//  Ports       : clk  - system clock
//                rst  - synchronous active-high reset
//                up   - upload_arbiter_if.slave (per-source inputs, merged
//                       output channel, sticky drop flags)
//  Revision    : 1.0 - initial release
// ============================================================================
module upload_arbiter #(
    parameter int N_SRC      = 2,
    parameter int FIFO_DEPTH = 64
) (
    input wire              clk,
    input wire              rst,
    upload_arbiter_if.slave up
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    localparam logic [c_CNT_W:0] c_DEPTH_EXT = (c_CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [c_CNT_W:0] c_FREE_ONE  = (c_CNT_W + 1)'(1);
    localparam logic [c_CNT_W:0] c_FREE_TWO  = (c_CNT_W + 1)'(2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    // Read-side requests into the per-source FIFOs
    logic [N_SRC-1:0]       w_pop;
    logic [N_SRC-1:0]       w_pkt_dec;
    // Per-source status back to the read side
    logic [N_SRC-1:0]       w_pkt_nz;
    logic [N_SRC-1:0]       w_drop;
    logic [N_SRC-1:0][16:0] w_head;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_SRC_W-1:0]     r_grant;
    logic [c_SRC_W-1:0]     r_rr_ptr;
    logic [c_SRC_W-1:0]     w_hit_idx;
    logic                   w_hit;
    logic                   w_handshake;
    logic                   r_out_last;
    logic [7:0]             r_out_data;
    logic [7:0]             r_out_source;

    // ------------------------------------------------------------------------
    // Write side: staging register + FIFO + complete-packet counter per source
    // ------------------------------------------------------------------------
    for (genvar s = 0; s < N_SRC; s++) begin : g_src
        logic [16:0]        r_mem [FIFO_DEPTH];
        logic [c_PTR_W-1:0] r_wr_ptr;
        logic [c_PTR_W-1:0] r_rd_ptr;
        logic [c_CNT_W-1:0] r_count;
        logic [c_CNT_W-1:0] r_pkt_cnt;
        logic               r_stg_valid;
        logic [15:0]        r_stg;
        logic               r_req_d;
        logic               r_drop;

        logic               w_accept;
        logic               w_end;
        logic               w_commit_try;
        logic               w_space_ok;
        logic               w_commit;
        logic               w_pkt_inc;
        logic [c_CNT_W:0]   w_free;

        assign w_accept     = up.in_req[s] & up.in_valid[s];
        assign w_end        = r_req_d & ~up.in_req[s];
        assign w_commit_try = r_stg_valid & (w_accept | w_end);

        // A pop in the same cycle frees a slot. Non-final commits keep one
        // slot in reserve so a started packet can always be closed.
        assign w_free     = c_DEPTH_EXT - {1'b0, r_count}
                          + {{c_CNT_W{1'b0}}, w_pop[s]};
        assign w_space_ok = w_end ? (w_free >= c_FREE_ONE)
                                  : (w_free >= c_FREE_TWO);
        assign w_commit   = w_commit_try & w_space_ok;
        assign w_pkt_inc  = w_commit & w_end;

        assign w_head[s]   = r_mem[r_rd_ptr];
        assign w_pkt_nz[s] = (r_pkt_cnt != '0);
        assign w_drop[s]   = r_drop;

        // Storage kept out of reset; pointers and counts define emptiness.
        always_ff @(posedge clk) begin
            if (!rst && w_commit) begin
                r_mem[r_wr_ptr] <= {w_end, r_stg};
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_count     <= '0;
                r_pkt_cnt   <= '0;
                r_stg_valid <= 1'b0;
                r_stg       <= '0;
                r_req_d     <= 1'b0;
                r_drop      <= 1'b0;
            end else begin
                r_req_d <= up.in_req[s];

                if (w_commit) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_commit_try && !w_space_ok) begin
                    r_drop <= 1'b1;
                end

                // The new byte always lands in the stage, even when the
                // previously staged byte could not be committed.
                if (w_accept) begin
                    r_stg_valid <= 1'b1;
                    r_stg       <= {up.in_source[8*s +: 8], up.in_data[8*s +: 8]};
                end else if (w_end) begin
                    r_stg_valid <= 1'b0;
                end

                if (w_pop[s]) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end

                case ({w_commit, w_pop[s]})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase

                case ({w_pkt_inc, w_pkt_dec[s]})
                    2'b10:   r_pkt_cnt <= r_pkt_cnt + 1'b1;
                    2'b01:   r_pkt_cnt <= r_pkt_cnt - 1'b1;
                    default: r_pkt_cnt <= r_pkt_cnt;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Round-robin scan: first source after r_rr_ptr holding a whole packet
    // ------------------------------------------------------------------------
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = r_rr_ptr;
        for (int i = 1; i <= N_SRC; i++) begin
            for (int j = 0; j < N_SRC; j++) begin
                if (!w_hit && w_pkt_nz[j] && (((int'(r_rr_ptr) + i) % N_SRC) == j)) begin
                    w_hit     = 1'b1;
                    w_hit_idx = c_SRC_W'(j);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read-side FSM
    // ------------------------------------------------------------------------
    assign w_handshake = (r_state == S_SEND) & up.out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = '0;
        w_pkt_dec   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_pop[r_grant] = 1'b1;
                w_state_nxt    = S_SEND;
            end
            S_SEND: begin
                if (w_handshake) begin
                    if (r_out_last) begin
                        w_pkt_dec[r_grant] = 1'b1;
                        w_state_nxt        = S_GAP;
                    end else begin
                        // Prefetch the next byte so valid stays high
                        w_pop[r_grant] = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_rr_ptr     <= c_SRC_W'(N_SRC - 1);
            r_out_last   <= 1'b0;
            r_out_data   <= 8'h00;
            r_out_source <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_hit) begin
                r_grant  <= w_hit_idx;
                r_rr_ptr <= w_hit_idx;
            end
            if (|w_pop) begin
                {r_out_last, r_out_source, r_out_data} <= w_head[r_grant];
            end
        end
    end

    assign up.out_req    = (r_state == S_FETCH) || (r_state == S_SEND);
    assign up.out_valid  = (r_state == S_SEND);
    assign up.out_data   = r_out_data;
    assign up.out_source = r_out_source;
    assign up.drop_flag  = w_drop;

endmodule
`default_nettype wire

// File: tb/tb_upload_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_upload_arbiter
//  Description : Directed self-checking bench for upload_arbiter (N_SRC=2,
//                FIFO_DEPTH=4): latency, round-robin, back-pressure,
//                overflow, edge cases and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_upload_arbiter;

    localparam int N_SRC      = 2;
    localparam int FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    upload_arbiter_if #(.N_SRC(N_SRC)) bus ();

    upload_arbiter #(
        .N_SRC      (N_SRC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .up  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Output log: {source, data} of every accepted byte, and packet count
    logic [15:0] log_q [$];
    logic [15:0] exp_q [$];
    logic [7:0]  pkt_q [$];
    int          pkt_starts = 0;
    logic        prev_req   = 1'b0;

    logic [7:0] bp_exp [6] = '{8'hC1, 8'hC2, 8'hC2, 8'hC2, 8'hC3, 8'hC4};
    logic       bp_rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            log_q.push_back({bus.out_source, bus.out_data});
        end
        if (bus.out_req && !prev_req) begin
            pkt_starts <= pkt_starts + 1;
        end
        prev_req <= bus.out_req;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [7:0] b);
        pkt_q.push_back(b);
    endtask

    task automatic expb(input logic [7:0] id, input logic [7:0] b);
        exp_q.push_back({id, b});
    endtask

    // Drives pkt_q on source s, one byte per cycle, then one cycle of req=0
    task automatic send(input int s, input logic [7:0] id);
        for (int i = 0; i < pkt_q.size(); i++) begin
            bus.in_req[s]            = 1'b1;
            bus.in_valid[s]          = 1'b1;
            bus.in_data[8*s +: 8]    = pkt_q[i];
            bus.in_source[8*s +: 8]  = id;
            tick();
        end
        bus.in_req[s]   = 1'b0;
        bus.in_valid[s] = 1'b0;
        tick();
        pkt_q.delete();
    endtask

    task automatic wait_log(input string tag, input int target);
        int k = 0;
        while (log_q.size() < target && k < 60) begin
            tick();
            k++;
        end
        chk(tag, log_q.size(), target);
        repeat (4) tick();
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!bus.out_valid && k < 20) begin
            tick();
            k++;
        end
        chk(tag, bus.out_valid, 1'b1);
    endtask

    task automatic expect_log(input string tag, input int base);
        chk({tag, "_len"}, log_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < log_q.size()) begin
                chk($sformatf("%s_%0d", tag, i), log_q[base + i], exp_q[i]);
            end
        end
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int p0;

        rst           = 1'b1;
        bus.in_req    = '0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.in_source = '0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // ---------------- reset state ----------------
        chk("rst_out_req",    bus.out_req,    1'b0);
        chk("rst_out_valid",  bus.out_valid,  1'b0);
        chk("rst_out_data",   bus.out_data,   8'h00);
        chk("rst_out_source", bus.out_source, 8'h00);
        chk("rst_drop_flag",  bus.drop_flag,  2'b00);

        // ---------------- contention, round 1: UART first ----------------
        base = log_q.size();
        p0   = pkt_starts;
        bus.in_req = 2'b11; bus.in_valid = 2'b10;
        bus.in_data = {8'hB1, 8'h00}; bus.in_source = {8'h02, 8'h01};
        tick();
        bus.in_valid = 2'b11; bus.in_data = {8'hB2, 8'hA1};
        tick();
        bus.in_data = {8'hB3, 8'hA2};
        tick();
        bus.in_req = 2'b00; bus.in_valid = 2'b00;
        tick();
        expb(8'h01, 8'hA1); expb(8'h01, 8'hA2);
        expb(8'h02, 8'hB1); expb(8'h02, 8'hB2); expb(8'h02, 8'hB3);
        wait_log("rr1_wait", base + 5);
        expect_log("rr1", base);
        chk("rr1_pkts", pkt_starts - p0, 2);

        // ---------------- contention, round 2: starts from UART again ----------------
        base = log_q.size();
        bus.in_req = 2'b11; bus.in_valid = 2'b11;
        bus.in_data = {8'hD1, 8'hC1};
        tick();
        bus.in_req = 2'b00; bus.in_valid = 2'b00;
        tick();
        expb(8'h01, 8'hC1); expb(8'h02, 8'hD1);
        wait_log("rr2_wait", base + 2);
        expect_log("rr2", base);

        // ---------------- single packet, cycle-exact latency ----------------
        base = log_q.size();
        add(8'h11); add(8'h22); add(8'h33);
        send(0, 8'h01);
        chk("lat_t0_req",    bus.out_req,   1'b0);
        tick();
        chk("lat_t1_req",    bus.out_req,   1'b1);
        chk("lat_t1_valid",  bus.out_valid, 1'b0);
        tick();
        chk("lat_t2_valid",  bus.out_valid, 1'b1);
        chk("lat_b0_data",   bus.out_data,  8'h11);
        chk("lat_b0_src",    bus.out_source, 8'h01);
        tick();
        chk("lat_b1_data",   bus.out_data,  8'h22);
        chk("lat_b1_valid",  bus.out_valid, 1'b1);
        tick();
        chk("lat_b2_data",   bus.out_data,  8'h33);
        tick();
        chk("lat_gap_req",   bus.out_req,   1'b0);
        chk("lat_gap_valid", bus.out_valid, 1'b0);
        repeat (3) tick();
        expb(8'h01, 8'h11); expb(8'h01, 8'h22); expb(8'h01, 8'h33);
        expect_log("single", base);

        // ---------------- back-pressure 1,0,0,1 ----------------
        base = log_q.size();
        bus.out_ready = 1'b0;
        add(8'hC1); add(8'hC2); add(8'hC3); add(8'hC4);
        send(1, 8'h02);
        wait_valid("bp_first_valid");
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("bp_valid%0d", i), bus.out_valid, 1'b1);
            chk($sformatf("bp_data%0d", i),  bus.out_data,  bp_exp[i]);
            bus.out_ready = bp_rdy[i];
            tick();
        end
        chk("bp_end_valid", bus.out_valid, 1'b0);
        repeat (3) tick();
        expb(8'h02, 8'hC1); expb(8'h02, 8'hC2); expb(8'h02, 8'hC3); expb(8'h02, 8'hC4);
        expect_log("bp", base);

        // ---------------- zero-byte packet and stray in_valid ----------------
        base = log_q.size();
        p0   = pkt_starts;
        bus.in_req[0] = 1'b1;
        tick();
        bus.in_req[0] = 1'b0;
        repeat (8) tick();
        chk("zero_pkt_none", pkt_starts - p0, 0);
        bus.in_valid[0] = 1'b1;
        bus.in_data[7:0] = 8'h99;
        repeat (3) tick();
        bus.in_valid[0] = 1'b0;
        add(8'h5A);
        send(0, 8'h01);
        expb(8'h01, 8'h5A);
        wait_log("stray_wait", base + 1);
        expect_log("stray", base);

        // ---------------- overflow with FIFO_DEPTH=4 ----------------
        chk("pre_ovf_drop", bus.drop_flag, 2'b00);
        base = log_q.size();
        bus.out_ready = 1'b0;
        add(8'h61); add(8'h62); add(8'h63); add(8'h64); add(8'h65); add(8'h66);
        send(0, 8'h01);
        chk("ovf_drop_flag", bus.drop_flag, 2'b01);
        repeat (4) tick();
        chk("ovf_hold_valid", bus.out_valid, 1'b1);
        chk("ovf_hold_data",  bus.out_data,  8'h61);
        bus.out_ready = 1'b1;
        expb(8'h01, 8'h61); expb(8'h01, 8'h62); expb(8'h01, 8'h63); expb(8'h01, 8'h66);
        wait_log("ovf_wait", base + 4);
        expect_log("ovf", base);

        // ---------------- reset mid-SEND ----------------
        bus.out_ready = 1'b0;
        add(8'h71); add(8'h72); add(8'h73);
        send(0, 8'h01);
        wait_valid("mid_first_valid");
        rst = 1'b1;
        tick();
        chk("mid_rst_req",    bus.out_req,    1'b0);
        chk("mid_rst_valid",  bus.out_valid,  1'b0);
        chk("mid_rst_data",   bus.out_data,   8'h00);
        chk("mid_rst_source", bus.out_source, 8'h00);
        chk("mid_rst_drop",   bus.drop_flag,  2'b00);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        base = log_q.size();
        repeat (8) tick();
        chk("mid_rst_discard", log_q.size() - base, 0);
        add(8'hA5); add(8'h5A);
        send(0, 8'h01);
        expb(8'h01, 8'hA5); expb(8'h01, 8'h5A);
        wait_log("post_rst_wait", base + 2);
        expect_log("post_rst", base);

        // ---------------- commit and pop on a full FIFO ----------------
        base = log_q.size();
        p0   = pkt_starts;
        bus.out_ready = 1'b0;
        add(8'h81); add(8'h82); add(8'h83); add(8'h84);
        send(0, 8'h01);
        repeat (5) tick();
        add(8'h91);
        send(0, 8'h01);
        bus.in_req[0]    = 1'b1;
        bus.in_valid[0]  = 1'b1;
        bus.in_data[7:0] = 8'hA1;
        tick();
        bus.in_req[0]   = 1'b0;
        bus.in_valid[0] = 1'b0;
        bus.out_ready   = 1'b1;
        tick();
        chk("full_no_drop", bus.drop_flag, 2'b00);
        expb(8'h01, 8'h81); expb(8'h01, 8'h82); expb(8'h01, 8'h83); expb(8'h01, 8'h84);
        expb(8'h01, 8'h91); expb(8'h01, 8'hA1);
        wait_log("full_wait", base + 6);
        expect_log("full", base);
        chk("full_pkts", pkt_starts - p0, 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
